response_uart_rx: RTL
=====================

Name: response_uart_rx

Overview:
- Serial receiver that captures 8-bit response bytes sent back by the external target over a single asynchronous line (8N1, LSB first).
- Holds the last good byte stable on response_data, which drives the 8-bit in_port of the response PIO read by the Nios II CPU.
- Also emits a one-cycle valid strobe and a sticky framing-error flag for optional IRQ/status PIO use.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 8..65535.
- SYNC_STAGES, 2, number of metastability flops on rxd; legal range 2..3.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; asynchronous assert, active-low
- rxd  input  1  asynchronous serial line; idles high
- err_clr  input  1  synchronous, one cycle; clears frame_error
- response_data  output  8  last correctly framed byte; held until the next good frame
- response_valid  output  1  one-cycle pulse when response_data updates
- frame_error  output  1  sticky; set on a bad stop bit
- busy  output  1  high while a frame is being received (state != IDLE)

Behaviour:
- Reset (async, reset_n low):
  - All outputs are 0 and the state is IDLE.
  - Sync flops preset to 1, so a low rxd is not seen as a start bit immediately after reset.
  - Reset mid-frame abandons the frame. response_data returns to 0.
- rxd passes through SYNC_STAGES flops. All decisions use the synchronized value rxs.
- Bit counter cnt is 16 bits, bit index idx is 3 bits, shift register sh is 8 bits.
- HALF = CLKS_PER_BIT/2, truncated.
- States:
  - IDLE: cnt=0. When rxs==0, go to START.
  - START: cnt increments each cycle. At cnt==HALF-1, sample rxs.
    - rxs==1 (glitch): return to IDLE, no output change.
    - rxs==0: cnt=0, idx=0, go to DATA.
  - DATA: cnt increments. At cnt==CLKS_PER_BIT-1, sample rxs into sh[7] and shift right (LSB arrives first), then cnt=0.
    - idx==7: go to STOP. Otherwise idx+1.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxs.
    - rxs==1: on the next edge response_data<=sh and response_valid=1 for exactly one cycle.
    - rxs==0: frame_error<=1 and response_data is unchanged.
    - Either way go to IDLE.
    - After a framing error, IDLE waits for rxs==1 before arming again. A break (line held low) therefore produces one error, not repeated frames.
- Latency: response_valid asserts 1 cycle after the mid-stop sample, about 9.5 bit times + SYNC_STAGES + 1 cycles after the start falling edge.
- Back-to-back frames: a start edge immediately after a good stop sample is accepted. No idle time is required beyond the remaining half stop bit.
- frame_error:
  - err_clr and a new error in the same cycle: the error wins and the flag stays 1.
  - err_clr with no new error: the flag clears the next cycle.
- response_valid and frame_error are never both newly asserted from the same frame.
- busy is combinational from state (state != IDLE). All other outputs are registered.
- No parity. The receiver does not resynchronize mid-frame; the sample timing relies on the transmitter baud being within ±2%.

Test Plan:
- Clock and reset: CLKS_PER_BIT=16, SYNC_STAGES=2 unless stated. Hold reset_n low for 5 cycles with rxd=1, then release.
  -> All outputs are 0 and busy=0 for 200 idle cycles.
- Send 0xA5 as 8N1 at 16 clk/bit.
  -> response_data=0xA5 with a single response_valid pulse. The pulse lands 155±1 cycles after the start edge. frame_error=0.
- Start glitch: rxd low for 4 cycles, then high.
  -> Returns to IDLE. busy drops by cycle HALF+3. No valid pulse, response_data unchanged.
- Send 0x3C with the stop bit forced low, then pulse err_clr while rxd=1.
  -> frame_error=1 and response_data still holds the previous byte. frame_error clears one cycle after err_clr.
- Back-to-back 0x01, 0xFF, 0x80 with no idle gap.
  -> Three valid pulses, with response_data 0x01, 0xFF, 0x80 in order.
- Assert reset_n low during DATA bit 4 of 0x55, then send 0x7E.
  -> Outputs clear immediately. No stale pulse. The next frame yields 0x7E correctly.

Source files
------------

// File: rtl/response_uart_rx.sv
// ---------------------------------------------------------------------------
// response_uart_rx
//   8N1 (LSB first) serial receiver for response bytes returned by the
//   external target. The last correctly framed byte is held on
//   response_data (feeds the response PIO in_port); a one-cycle strobe marks
//   each update and a sticky flag records bad stop bits.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (8..65535)
//   SYNC_STAGES   metastability flops on rxd (2..3)
//
// Ports
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   rxd            in   asynchronous serial line, idles high
//   err_clr        in   one-cycle synchronous clear of frame_error
//   response_data  out  [7:0] last good byte, held until the next good frame
//   response_valid out  one-cycle pulse when response_data updates
//   frame_error    out  sticky, set on a bad stop bit
//   busy           out  high while a frame is in progress
// ---------------------------------------------------------------------------
module response_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       err_clr,
    output logic [7:0] response_data,
    output logic       response_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam logic [15:0] LP_LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    logic [15:0]            r_cnt;
    logic [15:0]            w_cnt_nxt;
    logic [2:0]             r_idx;
    logic [2:0]             w_idx_nxt;
    logic [7:0]             r_sh;
    logic [7:0]             w_sh_nxt;
    logic [7:0]             r_data;
    logic [7:0]             w_data_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   r_ferr;
    logic                   w_ferr_nxt;
    // Set after a bad stop bit: IDLE ignores a low line until it has been
    // seen high, so a held break yields a single error instead of a stream.
    logic                   r_hold;
    logic                   w_hold_nxt;

    // Preset to 1 so a low line at reset release is not taken as a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sh    <= w_sh_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sh_nxt    = r_sh;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        // A new error below overrides this clear.
        w_ferr_nxt  = err_clr ? 1'b0 : r_ferr;
        w_hold_nxt  = r_hold;

        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (r_hold) begin
                    if (w_rxs) begin
                        w_hold_nxt = 1'b0;
                    end
                end else if (!w_rxs) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == LP_HALF_M1) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (r_cnt == LP_LAST) begin
                    w_cnt_nxt = '0;
                    w_sh_nxt  = {w_rxs, r_sh[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (r_cnt == LP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (w_rxs) begin
                        w_data_nxt  = r_sh;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                        w_hold_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign response_data  = r_data;
    assign response_valid = r_valid;
    assign frame_error    = r_ferr;
    assign busy           = (r_state != ST_IDLE);

endmodule
